// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port and downstream valid/ready stream signals for fifo_stream_reader.
// master = the reader, slave = FIFO plus downstream consumer.
interface fifo_stream_reader_if #(
    parameter int unsigned FIFO_WIDTH = 16
);
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        output fifo_rd_en,
        output m_valid,
        output m_data,
        input  fifo_data_out,
        input  fifo_empty,
        input  fifo_underflow,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        output fifo_data_out,
        output fifo_empty,
        output fifo_underflow,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: credit-based reads into a 2-entry skid buffer,
// presented as a full-throughput valid/ready stream, plus delivery/underflow stats.
module fifo_stream_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 underflow_err,
    fifo_stream_reader_if.master bus
);
    localparam int unsigned OCC_W = 2;

    logic [OCC_W-1:0]      occ, occ_next;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] head, head_next;
    logic [FIFO_WIDTH-1:0] tail, tail_next;
    logic [CNT_W-1:0]      rd_count_next;
    logic                  underflow_err_next;
    logic                  pop;
    logic [OCC_W-1:0]      credit;
    logic                  rd_en;

    // Read only while the buffer slots not yet spoken for (after this pop) can hold it.
    always_comb begin
        pop    = (occ != OCC_W'(0)) && bus.m_ready;
        credit = occ + OCC_W'(inflight) - OCC_W'(pop);
        rd_en  = rst_n && enable && !bus.fifo_empty && (credit < OCC_W'(2));
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != OCC_W'(0));
    assign bus.m_data     = head;

    // Skid buffer update: head is the oldest word, tail only used when occ == 2.
    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        case ({inflight, pop})
            2'b01: begin
                head_next = tail;
                occ_next  = occ - OCC_W'(1);
            end
            2'b10: begin
                if (occ == OCC_W'(0)) head_next = bus.fifo_data_out;
                else                  tail_next = bus.fifo_data_out;
                occ_next = occ + OCC_W'(1);
            end
            2'b11: begin
                if (occ == OCC_W'(2)) begin
                    head_next = tail;
                    tail_next = bus.fifo_data_out;
                end else begin
                    head_next = bus.fifo_data_out;
                end
            end
            default: ;
        endcase
    end

    // Statistics: clear beats increment, underflow set beats clear.
    always_comb begin
        rd_count_next      = rd_count;
        underflow_err_next = underflow_err;
        if (clr_stats)  rd_count_next = '0;
        else if (pop)   rd_count_next = rd_count + CNT_W'(1);
        if (bus.fifo_underflow) underflow_err_next = 1'b1;
        else if (clr_stats)     underflow_err_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ           <= '0;
            inflight      <= 1'b0;
            head          <= '0;
            tail          <= '0;
            rd_count      <= '0;
            underflow_err <= 1'b0;
        end else begin
            occ           <= occ_next;
            inflight      <= rd_en;
            head          <= head_next;
            tail          <= tail_next;
            rd_count      <= rd_count_next;
            underflow_err <= underflow_err_next;
        end
    end
endmodule
